// File: rtl/rf_score_arbiter.sv
// rf_score_arbiter: shares the register-file write port between the CPU and the
// button/target scoring logic. Button presses are synchronised, edge-detected and
// qualified by the target's lit state. Each scored hit adds to a saturating pending
// score, which is written to STATUS_REG on any cycle the CPU is not writing.
// Ports:
//   clock, reset         - processor clock, async active-high reset
//   btn_n[NUM_SRC]       - raw active-low buttons (asynchronous)
//   lit[NUM_SRC]         - target lit flags; a press scores only while lit
//   cpu_we/cpu_rd/cpu_data - processor regfile write request
//   rf_we/rf_rd/rf_data  - regfile write port (CPU pass-through or injection)
//   hit_pulse[NUM_SRC]   - one-cycle pulse per scored hit
//   pending              - current unwritten score
//   injecting            - arbiter owns the write port this cycle
//   starve               - sticky: score blocked by the CPU for MAX_WAIT cycles
`timescale 1ns/1ps
module rf_score_arbiter #(
    parameter int unsigned NUM_SRC     = 4,
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned STATUS_REG  = 30,
    parameter int unsigned HOLDOFF_CYC = 1,
    parameter int unsigned MAX_WAIT    = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] btn_n,
    input  logic [NUM_SRC-1:0] lit,
    input  logic               cpu_we,
    input  logic [4:0]         cpu_rd,
    input  logic [31:0]        cpu_data,
    output logic               rf_we,
    output logic [4:0]         rf_rd,
    output logic [31:0]        rf_data,
    output logic [NUM_SRC-1:0] hit_pulse,
    output logic [ACC_W-1:0]   pending,
    output logic               injecting,
    output logic               starve
);

    localparam int unsigned CNT_W  = $clog2(NUM_SRC + 1);
    localparam int unsigned SUM_W  = ACC_W + CNT_W;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    typedef enum logic [1:0] {IDLE, ARMED, HOLDOFF} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] s1, s2, h;
    logic [NUM_SRC-1:0] hits;
    logic [CNT_W-1:0]   hit_cnt;
    logic [SUM_W-1:0]   base;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   pending_next;
    logic [3:0]         hold_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               inj;

    // Hit detection, injection decision and saturating score update.
    // On an injection edge the old score is consumed, so only new hits remain.
    always_comb begin
        hits    = h & ~s2 & lit;
        hit_cnt = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            hit_cnt = hit_cnt + CNT_W'(hits[i]);
        end
        inj  = (state == ARMED) & ~cpu_we;
        base = inj ? '0 : SUM_W'(pending);
        sum  = base + SUM_W'(hit_cnt);
        pending_next = (sum > ACC_MAX) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    // Write-port mux: the CPU always wins; injection only fills idle cycles.
    always_comb begin
        rf_we     = inj | cpu_we;
        rf_rd     = inj ? 5'(STATUS_REG) : cpu_rd;
        rf_data   = inj ? 32'(pending) : cpu_data;
        injecting = inj;
    end

    // Synchronisers, hit pulses, score accumulator and arbitration FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1        <= '1;
            s2        <= '1;
            h         <= '1;
            hit_pulse <= '0;
            pending   <= '0;
            state     <= IDLE;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
            starve    <= 1'b0;
        end else begin
            s1        <= btn_n;
            s2        <= s1;
            h         <= s2;
            hit_pulse <= hits;
            pending   <= pending_next;
            case (state)
                IDLE: begin
                    if (pending_next != '0) state <= ARMED;
                end
                ARMED: begin
                    if (inj) begin
                        state    <= HOLDOFF;
                        hold_cnt <= 4'(HOLDOFF_CYC);
                        wait_cnt <= '0;
                        starve   <= 1'b0;
                    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
                        // Not injecting in ARMED means the CPU held the port.
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) starve <= 1'b1;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt <= 4'd1) begin
                        hold_cnt <= '0;
                        state    <= (pending_next != '0) ? ARMED : IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_score_arbiter.sv
// Directed self-checking bench for rf_score_arbiter: a default instance plus a
// 2-bit-accumulator instance for saturation, both driven by the same stimulus.
`timescale 1ns/1ps
module tb_rf_score_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  btn_n;
    logic [3:0]  lit;
    logic        cpu_we;
    logic [4:0]  cpu_rd;
    logic [31:0] cpu_data;

    logic        rf_we,   s_rf_we;
    logic [4:0]  rf_rd,   s_rf_rd;
    logic [31:0] rf_data, s_rf_data;
    logic [3:0]  hit_pulse, s_hit_pulse;
    logic [7:0]  pending;
    logic [1:0]  s_pending;
    logic        injecting, s_injecting;
    logic        starve, s_starve;

    int checks   = 0;
    int failures = 0;

    rf_score_arbiter u_dut (
        .clock(clock), .reset(reset), .btn_n(btn_n), .lit(lit),
        .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .hit_pulse(hit_pulse), .pending(pending),
        .injecting(injecting), .starve(starve)
    );

    rf_score_arbiter #(.ACC_W(2)) u_sat (
        .clock(clock), .reset(reset), .btn_n(btn_n), .lit(lit),
        .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
        .rf_we(s_rf_we), .rf_rd(s_rf_rd), .rf_data(s_rf_data),
        .hit_pulse(s_hit_pulse), .pending(s_pending),
        .injecting(s_injecting), .starve(s_starve)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; btn_n = 4'hF; lit = 4'h0;
        cpu_we = 1'b0; cpu_rd = 5'd0; cpu_data = 32'd0;
        #12;
        // Reset state and CPU pass-through while in reset.
        chk("rst_hit_pulse", 32'(hit_pulse), 32'h0);
        chk("rst_pending",   32'(pending),   32'h0);
        chk("rst_injecting", 32'(injecting), 32'h0);
        chk("rst_starve",    32'(starve),    32'h0);
        cpu_we = 1'b1; cpu_rd = 5'd5; cpu_data = 32'h1234; #1;
        chk("rst_rf_we",   32'(rf_we), 32'h1);
        chk("rst_rf_rd",   32'(rf_rd), 32'h5);
        chk("rst_rf_data", rf_data,    32'h1234);
        cpu_we = 1'b0;
        step(1);
        reset = 1'b0;
        step(2);
        chk("idle_pending",   32'(pending),   32'h0);
        chk("idle_injecting", 32'(injecting), 32'h0);

        // Single lit press: pulse on third edge, then immediate injection.
        lit = 4'b0001; btn_n = 4'b1110;
        step(2);
        chk("t1_no_pulse_early", 32'(hit_pulse), 32'h0);
        step(1);
        chk("t1_hit_pulse", 32'(hit_pulse), 32'h1);
        chk("t1_pending",   32'(pending),   32'h1);
        chk("t1_injecting", 32'(injecting), 32'h1);
        chk("t1_rf_we",     32'(rf_we),     32'h1);
        chk("t1_rf_rd",     32'(rf_rd),     32'd30);
        chk("t1_rf_data",   rf_data,        32'h1);
        step(1);
        chk("t1_pending_clr", 32'(pending),   32'h0);
        chk("t1_holdoff_inj", 32'(injecting), 32'h0);
        chk("t1_rf_we_off",   32'(rf_we),     32'h0);
        chk("t1_pulse_once",  32'(hit_pulse), 32'h0);
        step(1);
        chk("t1_held_no_pulse", 32'(hit_pulse), 32'h0);
        chk("t1_idle_inj",      32'(injecting), 32'h0);
        btn_n = 4'hF;
        step(3);

        // Press on an unlit target scores nothing.
        lit = 4'b0000; btn_n = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("t2_no_pulse", 32'(hit_pulse), 32'h0);
            chk("t2_rf_we",    32'(rf_we),     32'h0);
        end
        chk("t2_pending", 32'(pending), 32'h0);
        btn_n = 4'hF;
        step(3);

        // Two simultaneous hits while the CPU holds the port for 5 cycles.
        lit = 4'b1010; cpu_we = 1'b1; cpu_rd = 5'd7; cpu_data = 32'hAA; btn_n = 4'b0101;
        step(3);
        chk("t3_hit_pulse", 32'(hit_pulse), 32'hA);
        chk("t3_pending",   32'(pending),   32'h2);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1);
            chk("t3_cpu_inj",  32'(injecting), 32'h0);
            chk("t3_cpu_rd",   32'(rf_rd),     32'h7);
            chk("t3_cpu_data", rf_data,        32'hAA);
        end
        cpu_we = 1'b0; #1;
        chk("t3_inj",     32'(injecting), 32'h1);
        chk("t3_rf_rd",   32'(rf_rd),     32'd30);
        chk("t3_rf_data", rf_data,        32'h2);
        step(1);
        chk("t3_pending_clr", 32'(pending), 32'h0);
        btn_n = 4'hF;
        step(3);

        // New hit landing on the injection edge carries over.
        lit = 4'hF; cpu_we = 1'b1; btn_n = 4'b1000;
        step(1);
        btn_n = 4'b0000;
        step(2);
        chk("t4_pending3",  32'(pending),   32'h3);
        chk("t4_pulse012",  32'(hit_pulse), 32'h7);
        chk("t4_blocked",   32'(injecting), 32'h0);
        cpu_we = 1'b0; #1;
        chk("t4_inj",     32'(injecting), 32'h1);
        chk("t4_rf_data", rf_data,        32'h3);
        step(1);
        chk("t4_carry_pending", 32'(pending),   32'h1);
        chk("t4_pulse3",        32'(hit_pulse), 32'h8);
        chk("t4_holdoff",       32'(injecting), 32'h0);
        step(1);
        chk("t4_inj2",      32'(injecting), 32'h1);
        chk("t4_rf_rd2",    32'(rf_rd),     32'd30);
        chk("t4_rf_data2",  rf_data,        32'h1);
        step(1);
        chk("t4_pending_clr", 32'(pending), 32'h0);
        btn_n = 4'hF;
        step(3);

        // Starvation: CPU blocks a pending score for 70 cycles.
        lit = 4'b0001; cpu_we = 1'b1; cpu_rd = 5'd3; cpu_data = 32'h77; btn_n = 4'b1110;
        step(3);
        chk("t5_pending", 32'(pending), 32'h1);
        for (int i = 1; i <= 69; i++) begin
            step(1);
            if (i == 63) chk("t5_starve_63", 32'(starve), 32'h0);
            if (i == 64) chk("t5_starve_64", 32'(starve), 32'h1);
        end
        chk("t5_starve_held", 32'(starve),    32'h1);
        chk("t5_blocked",     32'(injecting), 32'h0);
        chk("t5_cpu_rd",      32'(rf_rd),     32'h3);
        cpu_we = 1'b0; #1;
        chk("t5_inj",     32'(injecting), 32'h1);
        chk("t5_rf_data", rf_data,        32'h1);
        step(1);
        chk("t5_starve_clr", 32'(starve),  32'h0);
        chk("t5_pending_clr", 32'(pending), 32'h0);
        btn_n = 4'hF;
        step(3);

        // Saturation on the 2-bit instance, then reset mid-stream.
        lit = 4'hF; cpu_we = 1'b1; cpu_rd = 5'd9; cpu_data = 32'h55; btn_n = 4'h0;
        step(3);
        chk("t6_dut_pending4", 32'(pending),   32'h4);
        chk("t6_sat_pending3", 32'(s_pending), 32'h3);
        btn_n = 4'hF;
        step(3);
        btn_n = 4'b1100;
        step(3);
        chk("t6_dut_pending6", 32'(pending),   32'h6);
        chk("t6_sat_hold3",    32'(s_pending), 32'h3);
        reset = 1'b1; #1;
        chk("t6_rst_pending",  32'(pending),   32'h0);
        chk("t6_rst_spending", 32'(s_pending), 32'h0);
        chk("t6_rst_rf_rd",    32'(s_rf_rd),   32'h9);
        chk("t6_rst_rf_data",  s_rf_data,      32'h55);
        cpu_we = 1'b0; #1;
        chk("t6_rst_inj",   32'(s_injecting), 32'h0);
        chk("t6_rst_rf_we", 32'(s_rf_we),     32'h0);
        step(1);
        chk("t6_rst_inj_dut", 32'(injecting), 32'h0);
        btn_n = 4'hF;
        reset = 1'b0;
        step(2);
        chk("t6_post_pending", 32'(s_pending), 32'h0);
        chk("t6_post_inj",     32'(injecting), 32'h0);
        chk("t6_post_rf_we",   32'(rf_we),     32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
